// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared hazard-unit state and forward-select types
package cpu_types_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MEMWAIT = 2'd1,
      FLUSH   = 2'd2
   } hz_state_t;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_t;

   localparam int WAIT_W = 16;

endpackage

// File: rtl/hazard_ctrl_fsm_fwd_match.sv
// rtl/hazard_ctrl_fsm_fwd_match.sv - forward select for one EX source operand
module fwd_match
   import cpu_types_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic [REG_W-1:0] src,
   input  logic             mem_regwrite,
   input  logic [REG_W-1:0] mem_wsel,
   input  logic             wb_regwrite,
   input  logic [REG_W-1:0] wb_wsel,
   output fwd_sel_t         sel
);

   // MEM holds the younger result, so it wins over WB; register 0 never forwards
   always_comb begin
      sel = FWD_RF;
      if (mem_regwrite && (mem_wsel != '0) && (mem_wsel == src))
         sel = FWD_MEM;
      else if (wb_regwrite && (wb_wsel != '0) && (wb_wsel == src))
         sel = FWD_WB;
   end

endmodule

// File: rtl/hazard_ctrl_fsm.sv
// rtl/hazard_ctrl_fsm.sv - pipeline hazard/stall/flush controller; HAZARD_STATS_EN adds perf counters
module hazard_ctrl_fsm
   import cpu_types_pkg::*;
#(
   parameter int NUM_SRC = 2,
   parameter int REG_W   = 5,
   parameter int TIMEOUT = 255
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_SRC-1:0][REG_W-1:0]   src_id,
   input  logic [NUM_SRC-1:0][REG_W-1:0]   src_ex,
   input  logic                            ex_memread,
   input  logic [REG_W-1:0]                ex_wsel,
   input  logic                            mem_regwrite,
   input  logic [REG_W-1:0]                mem_wsel,
   input  logic                            wb_regwrite,
   input  logic [REG_W-1:0]                wb_wsel,
   input  logic                            mem_dreq,
   input  logic                            dhit,
   input  logic                            ihit,
   input  logic                            branch_taken_mem,
   output logic [NUM_SRC-1:0][1:0]         fwd_sel,
   output logic                            pc_en,
   output logic                            ifid_en,
   output logic                            idex_en,
   output logic                            exmem_en,
   output logic                            memwb_en,
   output logic                            ifid_flush,
   output logic                            idex_flush,
   output logic                            exmem_flush,
   output logic [1:0]                      state,
   output logic                            mem_timeout,
   output logic [31:0]                     stall_cnt,
   output logic [31:0]                     flush_cnt
);

   localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);

   hz_state_t         cur_state;
   hz_state_t         nxt_state;
   logic              load_use;
   logic              flush_evt;
   logic [4:0]        en_v;      // {pc, ifid, idex, exmem, memwb}
   logic [2:0]        flush_v;   // {ifid, idex, exmem}
   logic [WAIT_W-1:0] wait_cnt;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
      fwd_sel_t sel;
      fwd_match #(.REG_W(REG_W)) u_fwd_match (
         .src          (src_ex[i]),
         .mem_regwrite (mem_regwrite),
         .mem_wsel     (mem_wsel),
         .wb_regwrite  (wb_regwrite),
         .wb_wsel      (wb_wsel),
         .sel          (sel)
      );
      assign fwd_sel[i] = sel;
   end

   always_comb begin
      load_use = 1'b0;
      for (int i = 0; i < NUM_SRC; i++)
         if (ex_memread && (ex_wsel != '0) && (ex_wsel == src_id[i]))
            load_use = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cur_state <= RUN;
      else
         cur_state <= nxt_state;
   end

   always_comb begin
      nxt_state = cur_state;
      case (cur_state)
         RUN: begin
            if (mem_dreq && !dhit)
               nxt_state = MEMWAIT;
            else if (branch_taken_mem && !ihit)
               nxt_state = FLUSH;
         end
         MEMWAIT: if (dhit) nxt_state = RUN;
         FLUSH:   if (ihit) nxt_state = RUN;
         default: nxt_state = RUN;
      endcase
   end

   // RUN priority: data wait, then branch flush, then load-use, then fetch stall
   always_comb begin
      en_v      = 5'b11111;
      flush_v   = 3'b000;
      flush_evt = 1'b0;
      case (cur_state)
         RUN: begin
            if (mem_dreq && !dhit) begin
               en_v = 5'b00000;
            end else if (branch_taken_mem && ihit) begin
               flush_v   = 3'b111;
               flush_evt = 1'b1;
            end else if (branch_taken_mem) begin
               en_v      = 5'b10000;
               flush_v   = 3'b111;
               flush_evt = 1'b1;
            end else if (load_use || !ihit) begin
               en_v    = 5'b00111;
               flush_v = 3'b010;
            end
         end
         MEMWAIT: if (!dhit) en_v = 5'b00000;
         FLUSH: begin
            flush_v = 3'b111;
            if (!ihit) en_v = 5'b10000;
         end
         default: en_v = 5'b00000;
      endcase
      if (rst) begin
         en_v      = 5'b00000;
         flush_v   = 3'b000;
         flush_evt = 1'b0;
      end
   end

   assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = en_v;
   assign {ifid_flush, idex_flush, exmem_flush}         = flush_v;
   assign state = cur_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else if ((cur_state == RUN) && (nxt_state == MEMWAIT)) begin
         wait_cnt <= '0;
      end else if ((cur_state == MEMWAIT) && (wait_cnt != TIMEOUT_V)) begin
         wait_cnt <= wait_cnt + WAIT_W'(1);
         if ((wait_cnt + WAIT_W'(1)) == TIMEOUT_V)
            mem_timeout <= 1'b1;
      end
   end

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (!pc_en && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 32'd1;
         if (flush_evt && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 32'd1;
      end
   end
`else
   logic stats_unused;
   assign stats_unused = flush_evt;
   assign stall_cnt    = '0;
   assign flush_cnt    = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_fsm.sv
// tb/tb_hazard_ctrl_fsm.sv - directed self-checking bench for hazard_ctrl_fsm
module tb_hazard_ctrl_fsm;

   localparam int NUM_SRC = 2;
   localparam int REG_W   = 5;
`ifdef HAZARD_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic                          clk = 1'b0;
   logic                          rst;
   logic [NUM_SRC-1:0][REG_W-1:0] src_id, src_ex;
   logic                          ex_memread, mem_regwrite, wb_regwrite;
   logic [REG_W-1:0]              ex_wsel, mem_wsel, wb_wsel;
   logic                          mem_dreq, dhit, ihit, branch_taken_mem;
   logic [NUM_SRC-1:0][1:0]       fwd_sel;
   logic                          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic                          ifid_flush, idex_flush, exmem_flush;
   logic [1:0]                    state;
   logic                          mem_timeout;
   logic [31:0]                   stall_cnt, flush_cnt;
   logic [4:0]                    en_v;
   logic [2:0]                    fl_v;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign en_v = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
   assign fl_v = {ifid_flush, idex_flush, exmem_flush};

   hazard_ctrl_fsm #(.NUM_SRC(NUM_SRC), .REG_W(REG_W), .TIMEOUT(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .src_id           (src_id),
      .src_ex           (src_ex),
      .ex_memread       (ex_memread),
      .ex_wsel          (ex_wsel),
      .mem_regwrite     (mem_regwrite),
      .mem_wsel         (mem_wsel),
      .wb_regwrite      (wb_regwrite),
      .wb_wsel          (wb_wsel),
      .mem_dreq         (mem_dreq),
      .dhit             (dhit),
      .ihit             (ihit),
      .branch_taken_mem (branch_taken_mem),
      .fwd_sel          (fwd_sel),
      .pc_en            (pc_en),
      .ifid_en          (ifid_en),
      .idex_en          (idex_en),
      .exmem_en         (exmem_en),
      .memwb_en         (memwb_en),
      .ifid_flush       (ifid_flush),
      .idex_flush       (idex_flush),
      .exmem_flush      (exmem_flush),
      .state            (state),
      .mem_timeout      (mem_timeout),
      .stall_cnt        (stall_cnt),
      .flush_cnt        (flush_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      src_id = '0; src_ex = '0;
      ex_memread = 1'b0; ex_wsel = '0;
      mem_regwrite = 1'b0; mem_wsel = '0;
      wb_regwrite = 1'b0; wb_wsel = '0;
      mem_dreq = 1'b0; dhit = 1'b0; ihit = 1'b1; branch_taken_mem = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      idle();
      cyc(); settle();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_en", 32'(en_v), 32'h00);
      chk("rst_flush", 32'(fl_v), 32'h0);
      chk("rst_timeout", 32'(mem_timeout), 32'd0);
      chk("rst_stall_cnt", stall_cnt, 32'd0);
      chk("rst_flush_cnt", flush_cnt, 32'd0);

      cyc(); rst = 1'b0; settle();
      chk("idle_en", 32'(en_v), 32'h1f);
      chk("idle_flush", 32'(fl_v), 32'h0);

      // forwarding
      mem_regwrite = 1'b1; mem_wsel = 5'd8; wb_regwrite = 1'b1; wb_wsel = 5'd8;
      src_ex[0] = 5'd8; #1;
      chk("fwd_mem_over_wb", 32'(fwd_sel[0]), 32'h1);
      chk("fwd_other_rf", 32'(fwd_sel[1]), 32'h0);
      mem_wsel = 5'd0; #1;
      chk("fwd_mem_r0_wb", 32'(fwd_sel[0]), 32'h2);
      wb_regwrite = 1'b0; #1;
      chk("fwd_none", 32'(fwd_sel[0]), 32'h0);
      mem_wsel = 5'd8; src_ex[1] = 5'd8; #1;
      chk("fwd_src1_mem", 32'(fwd_sel[1]), 32'h1);

      // load-use
      cyc(); idle();
      ex_memread = 1'b1; ex_wsel = 5'd3; src_id[1] = 5'd3; settle();
      chk("lu_en", 32'(en_v), 32'h07);
      chk("lu_flush", 32'(fl_v), 32'h2);
      cyc(); idle(); settle();
      chk("lu_state", 32'(state), 32'd0);
      chk("lu_release_en", 32'(en_v), 32'h1f);
      ex_memread = 1'b1; ex_wsel = 5'd0; #1;
      chk("lu_r0_no_stall", 32'(en_v), 32'h1f);

      // fetch miss stall
      cyc(); idle(); ihit = 1'b0; settle();
      chk("ihit_en", 32'(en_v), 32'h07);
      chk("ihit_flush", 32'(fl_v), 32'h2);

      // data wait with timeout reached on the fourth MEMWAIT cycle
      cyc(); idle(); mem_dreq = 1'b1; settle();
      chk("mw_entry_en", 32'(en_v), 32'h00);
      chk("mw_entry_flush", 32'(fl_v), 32'h0);
      for (int k = 0; k < 4; k++) begin
         cyc(); settle();
         chk("mw_state", 32'(state), 32'd1);
         chk("mw_en", 32'(en_v), 32'h00);
         chk("mw_timeout_low", 32'(mem_timeout), 32'd0);
      end
      cyc(); dhit = 1'b1; settle();
      chk("mw_dhit_en", 32'(en_v), 32'h1f);
      chk("mw_timeout_set", 32'(mem_timeout), 32'd1);
      cyc(); idle(); settle();
      chk("mw_back_run", 32'(state), 32'd0);
      chk("mw_stall_cnt", stall_cnt, STATS ? 32'd7 : 32'd0);

      // branch with fetch miss -> FLUSH
      branch_taken_mem = 1'b1; ihit = 1'b0; #1;
      chk("fl_entry_en", 32'(en_v), 32'h10);
      cyc(); settle();
      chk("fl_state", 32'(state), 32'd2);
      chk("fl_en", 32'(en_v), 32'h10);
      chk("fl_flush_held", 32'(fl_v), 32'h7);
      branch_taken_mem = 1'b0; ihit = 1'b1; #1;
      chk("fl_ihit_en", 32'(en_v), 32'h1f);
      cyc(); settle();
      chk("fl_back_run", 32'(state), 32'd0);
      chk("fl_flush_clear", 32'(fl_v), 32'h0);
      chk("fl_flush_cnt", flush_cnt, STATS ? 32'd1 : 32'd0);
      chk("fl_stall_cnt", stall_cnt, STATS ? 32'd7 : 32'd0);

      // branch with fetch hit -> immediate flush
      branch_taken_mem = 1'b1; #1;
      chk("br_flush", 32'(fl_v), 32'h7);
      chk("br_en", 32'(en_v), 32'h1f);
      cyc(); idle(); settle();
      chk("br_state", 32'(state), 32'd0);
      chk("br_flush_cnt", flush_cnt, STATS ? 32'd2 : 32'd0);

      // data wait beats branch, then reset mid-wait
      mem_dreq = 1'b1; branch_taken_mem = 1'b1; #1;
      chk("prio_flush", 32'(fl_v), 32'h0);
      chk("prio_en", 32'(en_v), 32'h00);
      cyc(); settle();
      chk("prio_state", 32'(state), 32'd1);
      chk("prio_mw_flush", 32'(fl_v), 32'h0);
      cyc(); rst = 1'b1; #1;
      chk("rst_mw_state", 32'(state), 32'd0);
      chk("rst_mw_timeout", 32'(mem_timeout), 32'd0);
      chk("rst_mw_en", 32'(en_v), 32'h00);
      chk("rst_mw_stall_cnt", stall_cnt, 32'd0);
      cyc(); rst = 1'b0; idle(); settle();
      chk("post_rst_en", 32'(en_v), 32'h1f);

      // reset mid-FLUSH
      branch_taken_mem = 1'b1; ihit = 1'b0;
      cyc(); settle();
      chk("fl2_state", 32'(state), 32'd2);
      rst = 1'b1; #1;
      chk("rst_fl_state", 32'(state), 32'd0);
      chk("rst_fl_flush", 32'(fl_v), 32'h0);
      cyc(); rst = 1'b0; idle(); settle();
      chk("post_rst_fl_state", 32'(state), 32'd0);
      chk("post_rst_fl_flush", 32'(fl_v), 32'h0);
      chk("post_rst_flush_cnt", flush_cnt, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
